// File: rtl/mux_channel_scanner.sv
// Drives the select lines of an external 4:1 mux one channel at a time and
// packs the four sampled bits into a scan word with a valid/ready handshake.

module mux_channel_scanner #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       mux_out,
    output logic       s0,
    output logic       s1,
    output logic [3:0] sample,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(DWELL - 1);

    state_t     state_r;
    logic [1:0] ch_r;
    logic [3:0] cnt_r;
    logic [2:0] shadow_r;
    logic [3:0] sample_r;
    logic       sample_valid_r;
    logic       busy_r;

    // Scan sequencer: channel stepping, dwell timing, capture and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            ch_r           <= 2'd0;
            cnt_r          <= 4'd0;
            shadow_r       <= 3'd0;
            sample_r       <= 4'd0;
            sample_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ch_r  <= 2'd0;
                    cnt_r <= 4'd0;
                    if (start) begin
                        state_r <= SCAN;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (cnt_r == LAST_CNT) begin
                        cnt_r <= 4'd0;
                        if (ch_r == 2'd3) begin
                            // Channel 3 goes straight into the word; the shadow
                            // only needs to keep the first three channels.
                            sample_r       <= {mux_out, shadow_r};
                            sample_valid_r <= 1'b1;
                            ch_r           <= 2'd0;
                            state_r        <= PRESENT;
                        end else begin
                            shadow_r[ch_r] <= mux_out;
                            ch_r           <= ch_r + 2'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                PRESENT: begin
                    ch_r  <= 2'd0;
                    cnt_r <= 4'd0;
                    if (sample_ready) begin
                        sample_valid_r <= 1'b0;
                        if (cont) begin
                            state_r <= SCAN;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        sample_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    ch_r           <= 2'd0;
                    cnt_r          <= 4'd0;
                    sample_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                end
            endcase
        end
    end

    assign s0           = ch_r[0];
    assign s1           = ch_r[1];
    assign sample       = sample_r;
    assign sample_valid = sample_valid_r;
    assign busy         = busy_r;

    mux_channel_scanner_checker u_checker (
        .clk          (clk),
        .rst          (rst),
        .s0           (s0),
        .s1           (s1),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy)
    );

endmodule

// Protocol properties of the scanner outputs.
module mux_channel_scanner_checker (
    input logic       clk,
    input logic       rst,
    input logic       s0,
    input logic       s1,
    input logic [3:0] sample,
    input logic       sample_valid,
    input logic       sample_ready,
    input logic       busy
);

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        sample_valid && !sample_ready |=> sample_valid && $stable(sample));

    a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
        !busy |-> !sample_valid && !s0 && !s1);

    a_present_select: assert property (@(posedge clk) disable iff (rst)
        sample_valid |-> !s0 && !s1);

endmodule

// File: doc/mux_channel_scanner.md
MUX_CHANNEL_SCANNER -- requirements
Module: mux_channel_scanner

Interface
REQ-001 Parameter: DWELL, default 2, clock cycles each channel select is held before sampling; legal range 1..16.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  single-cycle request to begin one scan of channels 0..3.
REQ-005 Port: cont  input  1  continuous mode; when 1 at result handshake, a new scan begins immediately.
REQ-006 Port: mux_out  input  1  output of the downstream 4:1 mux, sampled directly.
REQ-007 Port: s0  output  1  mux select LSB; equals channel index bit 0.
REQ-008 Port: s1  output  1  mux select MSB; equals channel index bit 1.
REQ-009 Port: sample  output  4  captured scan word; bit k holds mux_out sampled while channel k was selected.
REQ-010 Port: sample_valid  output  1  sample holds a complete, unconsumed scan word.
REQ-011 Port: sample_ready  input  1  consumer accepts sample when high together with sample_valid.
REQ-012 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, SCAN, PRESENT.
REQ-014 Internal 2-bit channel counter ch and 4-bit dwell counter cnt; s0 = ch[0] and s1 = ch[1], driven from registers (glitch-free).
REQ-015 IDLE: ch = 0, cnt = 0, busy = 0, sample_valid = 0; start = 1 at an edge -> SCAN with ch = 0, cnt = 0.
REQ-016 SCAN: cnt increments each cycle; at the edge where cnt == DWELL-1, mux_out is written to shadow bit ch and cnt clears.
REQ-017 SCAN, capture edge with ch < 3: ch increments, state remains SCAN.
REQ-018 SCAN, capture edge with ch == 3: sample <= {mux_out, shadow[2:0]}, sample_valid <= 1, ch <= 0, state -> PRESENT.
REQ-019 Latency: start accepted at edge E0 -> sample_valid first high after edge E0 + 4*DWELL; each channel held exactly DWELL cycles.
REQ-020 PRESENT: sample and sample_valid SHALL remain stable while sample_ready = 0 (no overwrite, no drop); s0 = s1 = 0.
REQ-021 PRESENT with sample_ready = 1: handshake completes at that edge; sample_valid <= 0; cont = 1 -> SCAN (ch = 0, cnt = 0), cont = 0 -> IDLE.
REQ-022 start asserted in SCAN or PRESENT SHALL be ignored; it is not queued.
REQ-023 cont changes during SCAN have no effect; cont is evaluated only at the handshake edge.
REQ-024 DWELL = 1: every cycle is a capture edge; the scan completes in 4 cycles.
REQ-025 sample retains its last value after the handshake until the next scan completes.

Reset
REQ-026 rst = 1 SHALL immediately, without a clock, force: state IDLE, ch = 0, cnt = 0, shadow = 0, s0 = 0, s1 = 0, sample = 4'b0000, sample_valid = 0, busy = 0.
REQ-027 Reset asserted mid-scan or in PRESENT SHALL discard the partial or pending word; the first post-reset action requires a new start.
REQ-028 After rst deasserts, the block SHALL remain in IDLE until start = 1 is sampled at a rising edge.

Verification
REQ-029 DWELL = 2, mux inputs I0..I3 = 1,0,1,1, start pulse at E0 -> {s1,s0} steps 00,01,10,11 for two cycles each; sample_valid rises after E0+8; sample = 4'b1101.
REQ-030 Hold sample_ready = 0 for 10 cycles in PRESENT, pulsing start and changing mux inputs -> sample and sample_valid unchanged, busy = 1; then ready = 1 -> valid drops next edge and state returns to IDLE.
REQ-031 cont = 1, ready held at 1, inputs 0,1,1,0 -> back-to-back scans with sample = 4'b0110 every 4*DWELL+1 cycles; clear cont -> IDLE after the next handshake.
REQ-032 Assert rst asynchronously while ch = 2 -> s0, s1, sample, sample_valid and busy go to 0 before the next clock edge; no sample_valid pulse follows.
REQ-033 DWELL = 1, inputs 0,0,0,1 -> select changes every cycle; sample = 4'b1000 valid after E0+4.
